bitmap_encoder32: RTL and testbench
===================================

# bitmap_encoder32

Sequential bitmap-to-index encoder, the reverse of the 5-to-32 one-hot decoder. It accepts a 32-bit request bitmap through a valid/ready handshake. It then emits the 5-bit index of every set bit, lowest index first, one per output handshake. It feeds index-addressed consumers such as register-file write ports and interrupt/event dispatch, and pairs with `decoder32` for bitmap round-trips.

## Interface
- `N`, 32: bitmap width. Only 32 is supported.
- `W`, 5: index width, equal to log2(N).
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_vec` holds a bitmap to load.
- `in_ready` out 1: block can accept a bitmap. High only in IDLE.
- `in_vec` in N: request bitmap. Sampled only on an input handshake.
- `out_valid` out 1: `out_index` holds a valid index.
- `out_ready` in 1: consumer takes the index this cycle.
- `out_index` out W: lowest set bit of the pending bitmap. Forced to 0 when `out_valid` = 0.
- `out_last` out 1: `out_index` is the final pending bit. Valid only with `out_valid`.
- `busy` out 1: state is SCAN.

## Operation
- Registered state consists of `state` (IDLE or SCAN) and `pending[N-1:0]`.
- Every output is a pure function of registered state. There is no combinational path from `in_*` or `out_ready` to any output.
- IDLE:
  - `in_ready` = 1, `out_valid` = 0.
  - Input handshake with `in_vec` != 0: `pending` <= `in_vec`, state <= SCAN.
  - Input handshake with `in_vec` = 0: bitmap is consumed and dropped. No output is produced and the state stays IDLE.
- SCAN:
  - `in_ready` = 0, `out_valid` = 1.
  - `out_index` is the lowest set bit of `pending`.
  - `out_last` = 1 when `pending` has exactly one bit set.
- Output handshake (`out_valid` & `out_ready`):
  - Clear bit `out_index` of `pending`.
  - If `out_last`, state <= IDLE.
- `in_valid` asserted during SCAN is ignored. The upstream must hold it until `in_ready`.
- No handshake in SCAN: `pending`, `out_index` and `out_last` hold stable. The output side never drops or changes an offered index.
- Reset:
  - At any `clk` edge with `rst` = 1: state <= IDLE, `pending` <= 0.
  - An in-flight bitmap is discarded.
  - `rst` overrides a simultaneous handshake.
- Reset values of the outputs: `in_ready` = 1, `out_valid` = 0, `out_index` = 0, `out_last` = 0, `busy` = 0.

## Timing
- Latency is one cycle. A bitmap accepted at edge k presents its first index in cycle k+1.
- Throughput is one index per cycle while `out_ready` = 1.
- A bitmap with M set bits needs M output handshakes. `in_ready` rises in the cycle after the last handshake.
- With `out_ready` held high, accept-to-accept takes M+1 cycles. That is 33 cycles for 32'hFFFF_FFFF.
- A zero bitmap takes 1 cycle, and `in_ready` stays high.
- Index arithmetic:
  - Indices run 0..31 with no wrap-around.
  - Bit 31 encodes to 5'd31, which is the maximum W-bit value.

## Structure
- Package `encoder_pkg` holds:
  - `N` and `W` as localparams.
  - `typedef enum logic {S_IDLE, S_SCAN} encoder_state_t`.
- Sub-module `priority_encoder32` is combinational and has three ports:
  - input `in[31:0]`
  - output `out[4:0]`: index of the lowest set bit, or 0 when `in` = 0
  - output `any`: OR of `in`
- `out_last` is derived as `pending & (pending - 1)` == 0.
- Estimated size: about 150 lines of RTL across the two modules.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid` = 1 and `in_vec` = 32'h1. Required: `in_ready` = 1, `out_valid` = 0, `out_index` = 0 and `busy` = 0 throughout and after.
- **Basic scan:** load `in_vec` = 32'h8000_0011 with `out_ready` = 1. Required: `out_index` reads 0, 4, 31 on consecutive cycles. `out_last` is high only with 31, and `in_ready` = 1 on the next cycle.
- **Backpressure:** load 32'h0000_0006 and hold `out_ready` = 0 for 3 cycles. Required: `out_index` = 1 and `out_valid` = 1 stable throughout. After `out_ready` rises, the indices are 1 then 2.
- **Zero and all-ones:**
  - A zero bitmap produces no `out_valid`, and `in_ready` never drops.
  - 32'hFFFF_FFFF produces indices 0..31 in order, 33 cycles accept-to-accept.
  - `in_valid` held high with 32'h1 during SCAN is ignored.
- **Reset mid-scan:** load 32'h0000_00F0, complete 2 handshakes (indices 4, 5), then pulse `rst`. Required: `out_valid` = 0 the next cycle, indices 6 and 7 are never emitted, and `in_ready` = 1.
- **Round-trip:** drive `decoder32` with `in` = `out_index` and `ena` = `out_valid & out_ready`. Accumulate the OR of its outputs over 1000 random bitmaps. Required: the accumulated value equals each loaded `in_vec` exactly.

Source files
------------

// File: rtl/bitmap_encoder32_pkg.sv
// Shared parameters and state encoding for the bitmap-to-index encoder.
package encoder_pkg;

    localparam int N = 32;
    localparam int W = 5;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } encoder_state_t;

    // Clears the lowest set bit of a bitmap. A result of zero means the
    // argument had at most one bit set.
    function automatic logic [N-1:0] clear_lowest(input logic [N-1:0] v);
        return v & (v - N'(1));
    endfunction

endpackage

// File: rtl/bitmap_encoder32_penc.sv
// Combinational lowest-set-bit encoder over a 32-bit bitmap.
// out is 0 when no bit is set; any tells the two cases apart.
module priority_encoder32
    import encoder_pkg::*;
(
    input  logic [N-1:0] in,
    output logic [W-1:0] out,
    output logic         any
);

    // Scan from the top down so the lowest set bit wins the last assignment.
    always_comb begin
        out = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                out = W'(i);
            end
        end
    end

    assign any = |in;

endmodule

// File: rtl/bitmap_encoder32.sv
// Sequential bitmap-to-index encoder: loads a 32-bit bitmap, then emits the
// index of each set bit, lowest first, one per output handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a new bitmap; a zero bitmap is consumed and dropped
//   S_SCAN | offering the lowest pending index until the bitmap is empty
//
// All outputs decode registered state only; no input reaches an output
// combinationally.
module bitmap_encoder32
    import encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_index,
    output logic         out_last,
    output logic         busy
);

    encoder_state_t r_state;
    logic [N-1:0]   r_pending;

    logic [W-1:0]   w_idx;
    logic           w_any;
    logic [N-1:0]   w_rest;
    logic           w_scan;
    logic           w_last;
    logic           w_in_hs;
    logic           w_out_hs;

    priority_encoder32 u_penc (
        .in  (r_pending),
        .out (w_idx),
        .any (w_any)
    );

    // Pending bitmap with the currently offered (lowest) bit removed.
    assign w_rest   = clear_lowest(r_pending);
    assign w_scan   = (r_state == S_SCAN);
    assign w_last   = w_any && (w_rest == '0);
    assign w_in_hs  = !w_scan && in_valid;
    assign w_out_hs = w_scan && out_ready;

    assign in_ready  = !w_scan;
    assign out_valid = w_scan;
    assign busy      = w_scan;
    assign out_index = w_scan ? w_idx : '0;
    assign out_last  = w_scan && w_last;

    // State and pending-bitmap update; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_hs && (in_vec != '0)) begin
                        r_pending <= in_vec;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_out_hs) begin
                        r_pending <= w_rest;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmap_encoder32.sv
// Self-checking bench for bitmap_encoder32: table-driven bitmaps plus
// hand-written sequences, with a queue of expected indices built from each
// accepted bitmap and compared on every output handshake.
module tb_bitmap_encoder32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;

    bitmap_encoder32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
    } exp_t;

    typedef struct {
        logic [31:0] vec;
        int          count;
        int          first;
        int          lastidx;
    } vec_t;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    int emitted[$];
    logic [31:0] cur_vec;
    logic [31:0] acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the model, account for the
    // handshakes this cycle, then advance to just after the next edge.
    task automatic cycle();
        exp_t e;
        bit   hs_in;
        bit   hs_out;
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() == 0});
        chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
        if (!out_valid) begin
            chk("idx_when_idle", {27'b0, out_index}, 32'd0);
            chk("last_when_idle", {31'b0, out_last}, 32'd0);
        end
        hs_out = out_valid && out_ready && !rst;
        hs_in  = in_ready && in_valid && !rst;
        if (hs_out) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("out_index", {27'b0, out_index}, e.idx);
                chk("out_last", {31'b0, out_last}, {31'b0, e.last});
                acc = acc | (32'd1 << out_index);
                emitted.push_back(int'(out_index));
                if (e.last) chk("round_trip", acc, cur_vec);
            end
        end
        if (hs_in && in_vec != 32'd0) begin
            int hi;
            hi = 0;
            for (int i = 0; i < 32; i++) if (in_vec[i]) hi = i;
            for (int i = 0; i < 32; i++) begin
                if (in_vec[i]) begin
                    e.idx  = i;
                    e.last = (i == hi);
                    q.push_back(e);
                end
            end
            cur_vec = in_vec;
            acc     = 32'd0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            acc = 32'd0;
        end
    endtask

    task automatic load(input logic [31:0] v);
        chk("load_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_vec   = v;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        while (!in_ready && n < 200) begin
            cycle();
            n++;
        end
        if (!in_ready) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        vec_t tbl[8];
        int   n;

        tbl[0] = '{32'h8000_0011, 3, 0, 31};
        tbl[1] = '{32'h0000_0006, 2, 1, 2};
        tbl[2] = '{32'hFFFF_FFFF, 32, 0, 31};
        tbl[3] = '{32'h0000_0001, 1, 0, 0};
        tbl[4] = '{32'h8000_0000, 1, 31, 31};
        tbl[5] = '{32'h0000_0000, 0, 0, 0};
        tbl[6] = '{32'h0000_00F0, 4, 4, 7};
        tbl[7] = '{32'hAAAA_AAAA, 16, 1, 31};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 32'h1;
        out_ready = 1'b1;
        cur_vec   = 32'd0;
        acc       = 32'd0;
        @(posedge clk);
        #1;

        // Reset held with a pending request: stays idle throughout and after.
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_out_index", {27'b0, out_index}, 32'd0);
            cycle();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        cycle();

        // Table: full-rate scans; drain length equals popcount, so
        // accept-to-accept is popcount + 1 cycles.
        for (int t = 0; t < 8; t++) begin
            emitted.delete();
            load(tbl[t].vec);
            drain(n);
            chk("scan_cycles", n, tbl[t].count);
            chk("emit_count", emitted.size(), tbl[t].count);
            if (tbl[t].count > 0 && emitted.size() > 0) begin
                chk("first_index", emitted[0], tbl[t].first);
                chk("last_index", emitted[emitted.size() - 1], tbl[t].lastidx);
            end
            cycle();
        end

        // Backpressure: offered index holds while out_ready is low.
        emitted.delete();
        out_ready = 1'b0;
        load(32'h0000_0006);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_index", {27'b0, out_index}, 32'd1);
            chk("bp_last", {31'b0, out_last}, 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        drain(n);
        chk("bp_count", emitted.size(), 2);
        if (emitted.size() == 2) begin
            chk("bp_idx0", emitted[0], 1);
            chk("bp_idx1", emitted[1], 2);
        end

        // Zero bitmap: consumed with no output and in_ready never drops.
        load(32'h0);
        chk("zero_ready", {31'b0, in_ready}, 32'd1);
        chk("zero_valid", {31'b0, out_valid}, 32'd0);
        cycle();

        // in_valid held during SCAN is ignored.
        emitted.delete();
        load(32'h0000_0003);
        in_valid = 1'b1;
        in_vec   = 32'h1;
        drain(n);
        in_valid = 1'b0;
        chk("ign_count", emitted.size(), 2);
        cycle();

        // Reset mid-scan: 4 and 5 taken, then reset drops 6 and 7.
        emitted.delete();
        load(32'h0000_00F0);
        cycle();
        cycle();
        chk("mid_emitted", emitted.size(), 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_index", {27'b0, out_index}, 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        chk("mid_no_more", emitted.size(), 2);

        // Random bitmaps with random backpressure; round trip checked on
        // each final handshake.
        for (int r = 0; r < 1000; r++) begin
            logic [31:0] v;
            int          guard;
            v = $urandom();
            if ($urandom_range(0, 15) == 0) v = 32'd0;
            if ($urandom_range(0, 7) == 0) v = v & (32'd1 << $urandom_range(0, 31));
            out_ready = 1'b1;
            load(v);
            guard = 0;
            while (!in_ready && guard < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                cycle();
                guard++;
            end
            if (!in_ready) chk("rand_timeout", 32'd1, 32'd0);
        end
        out_ready = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
